rib_arb2: RTL and testbench

Two-master RIB arbiter that shares one downstream RIB slave (SDRAM or peripheral port) between two upstream masters, for example the core data port and a DMA engine. It sits between the masters and the slave, uses round-robin request arbitration, and supports up to OUTS_DEPTH in-flight requests. Responses are routed back in order through an owner FIFO. All forwarding is combinational; only the arbitration and ordering state is registered.

---
 rtl/rib_arb2_if.sv | 18 +
 rtl/rib_arb2.sv | 88 ++++++++
 tb/tb_rib_arb2.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rib_arb2_if.sv
// RIB point-to-point bus: request channel (addr..req/gnt) and response channel (rsp/rdata/rdy).
// A master drives the request payload and rdy; a slave answers with gnt, rsp and rdata.
interface rib_arb2_if;
  logic [31:0] addr;
  logic        wrcs;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        req;
  logic        gnt;
  logic        rsp;
  logic [31:0] rdata;
  logic        rdy;

  modport master (output addr, wrcs, mask, wdata, req, rdy,
                  input  gnt, rsp, rdata);
  modport slave  (input  addr, wrcs, mask, wdata, req, rdy,
                  output gnt, rsp, rdata);
endinterface

// File: rtl/rib_arb2.sv
// Two-master RIB arbiter: round-robin request selection onto one slave, with in-order
// response routing through an owner FIFO of up to OUTS_DEPTH outstanding requests.
module rib_arb2 #(
  parameter int OUTS_DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  rib_arb2_if.slave  ribm0,
  rib_arb2_if.slave  ribm1,
  rib_arb2_if.master ribs,
  output logic     o_err
);
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  logic [1:0]       req, rdy;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [(1<<PW)-1:0] owner;
  logic             last_gnt, lock, sel_q, sel;
  logic             full, empty, head, gnt_ok, push, pop;

  assign req = {ribm1.req, ribm0.req};
  assign rdy = {ribm1.rdy, ribm0.rdy};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A forwarded request stalled by the slave pins the selection so the payload stays stable.
  always_comb begin
    sel = req[1];
    if (lock)                sel = sel_q;
    else if (req[0] & req[1]) sel = ~last_gnt;
  end

  assign full  = (count == CW'(OUTS_DEPTH));
  assign empty = (count == '0);
  assign head  = owner[rd_ptr];

  assign ribs.addr  = sel ? ribm1.addr  : ribm0.addr;
  assign ribs.wrcs  = sel ? ribm1.wrcs  : ribm0.wrcs;
  assign ribs.mask  = sel ? ribm1.mask  : ribm0.mask;
  assign ribs.wdata = sel ? ribm1.wdata : ribm0.wdata;
  assign ribs.req   = i_rstn & req[sel] & ~full;

  assign gnt_ok    = i_rstn & ribs.gnt & ~full;
  assign ribm0.gnt = gnt_ok & ~sel;
  assign ribm1.gnt = gnt_ok & sel;

  // With nothing outstanding the slave side stays ready so a stray response drains.
  assign ribm0.rsp   = i_rstn & ~empty & ~head & ribs.rsp;
  assign ribm1.rsp   = i_rstn & ~empty &  head & ribs.rsp;
  assign ribm0.rdata = ribs.rdata;
  assign ribm1.rdata = ribs.rdata;
  assign ribs.rdy    = i_rstn & (empty | rdy[head]);

  assign push = ribs.req & ribs.gnt;
  assign pop  = ribs.rsp & ribs.rdy & ~empty;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      owner    <= '0;
      last_gnt <= 1'b1;
      lock     <= 1'b0;
      sel_q    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      lock  <= ribs.req & ~ribs.gnt;
      sel_q <= sel;
      if (push) begin
        owner[wr_ptr] <= sel;
        wr_ptr        <= ptr_inc(wr_ptr);
        last_gnt      <= sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ribs.rsp & empty) o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rib_arb2.sv
// Directed bench for rib_arb2 (OUTS_DEPTH = 2): ties, lock, full stall, backpressure,
// stray response and reset mid-flight.
module tb_rib_arb2;
  logic i_clk = 1'b0;
  logic i_rstn;
  logic o_err;
  int   npass = 0;
  int   ntotal = 0;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;

  rib_arb2_if m0 ();
  rib_arb2_if m1 ();
  rib_arb2_if s ();

  rib_arb2 #(.OUTS_DEPTH(2)) dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .ribm0 (m0),
    .ribm1 (m1),
    .ribs  (s),
    .o_err (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    i_rstn = 1'b0;
    m0.addr = A0; m0.wrcs = 1'b0; m0.mask = 4'hF; m0.wdata = 32'h0; m0.req = 1'b1; m0.rdy = 1'b1;
    m1.addr = A1; m1.wrcs = 1'b1; m1.mask = 4'h3; m1.wdata = 32'h5; m1.req = 1'b1; m1.rdy = 1'b1;
    s.gnt = 1'b1; s.rsp = 1'b1; s.rdata = 32'h0;

    // Reset: everything forced low even with active inputs
    tick(); tick(); settle();
    chk1("rst_sreq", s.req, 1'b0);
    chk1("rst_gnt0", m0.gnt, 1'b0);
    chk1("rst_gnt1", m1.gnt, 1'b0);
    chk1("rst_rsp0", m0.rsp, 1'b0);
    chk1("rst_rsp1", m1.rsp, 1'b0);
    chk1("rst_srdy", s.rdy, 1'b0);
    chk1("rst_err", o_err, 1'b0);

    // Alternating ties
    tick(); i_rstn = 1'b1; s.rsp = 1'b0; settle();
    chk1("tie0_gnt0", m0.gnt, 1'b1);
    chk1("tie0_gnt1", m1.gnt, 1'b0);
    chk("tie0_addr", s.addr, A0);
    tick(); settle();
    chk1("tie1_gnt1", m1.gnt, 1'b1);
    chk1("tie1_gnt0", m0.gnt, 1'b0);
    chk("tie1_addr", s.addr, A1);
    tick(); s.rsp = 1'b1; s.rdata = 32'h1111_0000; settle();
    chk1("tie2_full_req", s.req, 1'b0);
    chk1("tie2_rsp0", m0.rsp, 1'b1);
    chk1("tie2_rsp1", m1.rsp, 1'b0);
    chk("tie2_rdata", m0.rdata, 32'h1111_0000);
    tick(); s.rdata = 32'h2222_0001; settle();
    chk1("tie3_gnt0", m0.gnt, 1'b1);
    chk1("tie3_rsp1", m1.rsp, 1'b1);
    chk("tie3_rdata1", m1.rdata, 32'h2222_0001);
    tick(); settle();
    chk1("tie4_gnt1", m1.gnt, 1'b1);
    chk1("tie4_rsp0", m0.rsp, 1'b1);
    tick(); m0.req = 1'b0; m1.req = 1'b0; settle();
    chk1("tie5_rsp1", m1.rsp, 1'b1);
    chk1("tie5_rsp0", m0.rsp, 1'b0);

    // Lock while the slave stalls; last grant was m1 so an unlocked tie would pick m0
    tick(); s.rsp = 1'b0; s.gnt = 1'b0; m1.req = 1'b1; settle();
    chk("lk0_addr", s.addr, A1);
    chk1("lk0_sreq", s.req, 1'b1);
    tick(); m0.req = 1'b1; settle();
    chk("lk1_addr", s.addr, A1);
    chk1("lk1_gnt0", m0.gnt, 1'b0);
    tick(); settle();
    chk("lk2_addr", s.addr, A1);
    tick(); s.gnt = 1'b1; settle();
    chk1("lk3_gnt1", m1.gnt, 1'b1);
    chk1("lk3_gnt0", m0.gnt, 1'b0);
    tick(); m1.req = 1'b0; settle();
    chk1("lk4_gnt0", m0.gnt, 1'b1);
    chk("lk4_addr", s.addr, A0);

    // Full stall: two outstanding (m1, m0), third request from m1
    tick(); m0.req = 1'b0; m1.req = 1'b1; settle();
    chk1("full0_sreq", s.req, 1'b0);
    chk1("full0_gnt1", m1.gnt, 1'b0);
    tick(); s.rsp = 1'b1; settle();
    chk1("full1_sreq", s.req, 1'b0);
    chk1("full1_gnt1", m1.gnt, 1'b0);
    chk1("full1_rsp1", m1.rsp, 1'b1);
    tick(); s.rsp = 1'b0; settle();
    chk1("full2_gnt1", m1.gnt, 1'b1);
    chk1("full2_sreq", s.req, 1'b1);

    // Response backpressure: head is m0, then m1
    tick(); m1.req = 1'b0; s.rsp = 1'b1; s.rdata = 32'hDEADBEEF; m0.rdy = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      chk1("bp_srdy", s.rdy, 1'b0);
      chk1("bp_rsp0", m0.rsp, 1'b1);
      chk1("bp_rsp1", m1.rsp, 1'b0);
      chk("bp_rdata", m0.rdata, 32'hDEADBEEF);
      if (i < 3) begin tick(); settle(); end
    end
    tick(); m0.rdy = 1'b1; settle();
    chk1("bp_rel_srdy", s.rdy, 1'b1);
    chk1("bp_rel_rsp0", m0.rsp, 1'b1);
    tick(); settle();
    chk1("bp_next_rsp1", m1.rsp, 1'b1);
    chk1("bp_next_rsp0", m0.rsp, 1'b0);

    // Stray response with FIFO empty
    tick(); m0.rdy = 1'b0; m1.rdy = 1'b0; settle();
    chk1("stray_srdy", s.rdy, 1'b1);
    chk1("stray_rsp0", m0.rsp, 1'b0);
    chk1("stray_rsp1", m1.rsp, 1'b0);
    chk1("stray_err_pre", o_err, 1'b0);
    tick(); s.rsp = 1'b0; m0.rdy = 1'b1; m1.rdy = 1'b1; settle();
    chk1("stray_err", o_err, 1'b1);
    tick(); settle();
    chk1("stray_err_hold", o_err, 1'b1);

    // Reset mid-flight with two outstanding
    tick(); m0.req = 1'b1; m1.req = 1'b1; settle();
    chk1("rmf0_gnt0", m0.gnt, 1'b1);
    tick(); settle();
    chk1("rmf1_gnt1", m1.gnt, 1'b1);
    tick(); i_rstn = 1'b0; s.rsp = 1'b1; settle();
    chk1("rmf_rst_sreq", s.req, 1'b0);
    chk1("rmf_rst_gnt0", m0.gnt, 1'b0);
    chk1("rmf_rst_gnt1", m1.gnt, 1'b0);
    chk1("rmf_rst_rsp0", m0.rsp, 1'b0);
    chk1("rmf_rst_rsp1", m1.rsp, 1'b0);
    chk1("rmf_rst_srdy", s.rdy, 1'b0);
    tick(); i_rstn = 1'b1; s.rsp = 1'b0; settle();
    chk1("rmf_err_clr", o_err, 1'b0);
    chk1("rmf_tie_gnt0", m0.gnt, 1'b1);
    chk("rmf_tie_addr", s.addr, A0);
    tick(); settle();
    chk1("rmf_gnt1", m1.gnt, 1'b1);
    tick(); settle();
    chk1("rmf_full_sreq", s.req, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
